// File: rtl/seqdet_pkg.sv
// Shared constants, width helpers and the length mask used by the
// programmable serial sequence detector.
package seqdet_pkg;

  localparam int SEQDET_MASK_W = 32;

  localparam logic [7:0] SEQDET_DEFAULT_PATTERN = 8'b0000_1011;
  localparam int         SEQDET_DEFAULT_LEN     = 4;
  localparam bit         SEQDET_DEFAULT_OVERLAP = 1'b0;

  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } overlap_e;

  // Width able to hold 0..max_len.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Width able to hold 0..max_len-1 (history depth).
  function automatic int fill_width(input int max_len);
    return (max_len <= 2) ? 1 : $clog2(max_len);
  endfunction

  // Right-aligned mask with the low len bits set.
  function automatic logic [SEQDET_MASK_W-1:0] len_mask(input int unsigned len);
    logic [SEQDET_MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < SEQDET_MASK_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seqdet_sat_cnt.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module seqdet_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seqdet_mealy_prog.sv
// Run-time programmable Mealy sequence detector with zero-latency match
// output, overlap/non-overlap modes and a saturating match counter.
module seqdet_mealy_prog
  import seqdet_pkg::*;
#(
  parameter int                 MAX_LEN         = 8,
  parameter int                 CNT_W           = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(SEQDET_DEFAULT_PATTERN),
  parameter int                 DEFAULT_LEN     = SEQDET_DEFAULT_LEN,
  parameter bit                 DEFAULT_OVERLAP = SEQDET_DEFAULT_OVERLAP
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic                             w,
  input  logic                             cfg_load,
  input  logic [MAX_LEN-1:0]               cfg_pattern,
  input  logic [len_width(MAX_LEN)-1:0]    cfg_len,
  input  logic                             cfg_overlap,
  output logic                             z,
  output logic [CNT_W-1:0]                 match_count,
  output logic [fill_width(MAX_LEN)-1:0]   fill
);

  localparam int LEN_W  = len_width(MAX_LEN);
  localparam int FILL_W = fill_width(MAX_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);

  // Stream handshake: w is consumed on any rising edge where in_valid is
  // high and cfg_load is low; there is no backpressure. cfg_load wins.

  logic [MAX_LEN-2:0]  hist, hist_next;
  logic [FILL_W-1:0]   fill_next;
  logic [MAX_LEN-1:0]  pattern, pattern_next;
  logic [LEN_W-1:0]    len, len_next;
  overlap_e            overlap, overlap_next;

  logic [MAX_LEN-1:0]  window;
  logic [MAX_LEN-1:0]  mask;
  logic                fill_ok;
  logic                match;

  always_comb begin
    window  = {hist, w};
    mask    = MAX_LEN'(len_mask(32'(len)));
    // fill >= len-1 written without a subtraction that could underflow.
    fill_ok = (32'(fill) + 32'd1) >= 32'(len);
    match   = in_valid && !cfg_load && (len != '0) && fill_ok &&
              (((window ^ pattern) & mask) == '0);
  end

  // Registers are already cleared during reset; gating keeps z quiet too.
  assign z = match && reset;

  always_comb begin
    hist_next    = hist;
    fill_next    = fill;
    pattern_next = pattern;
    len_next     = len;
    overlap_next = overlap;
    if (cfg_load) begin
      pattern_next = cfg_pattern;
      len_next     = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      overlap_next = overlap_e'(cfg_overlap);
      fill_next    = '0;
    end else if (in_valid) begin
      hist_next = window[MAX_LEN-2:0];
      if (match && (overlap == OVL_OFF)) begin
        fill_next = '0;
      end else if (fill != FILL_MAX) begin
        fill_next = fill + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= DEFAULT_PATTERN;
      len     <= LEN_W'(DEFAULT_LEN);
      overlap <= overlap_e'(DEFAULT_OVERLAP);
    end else begin
      hist    <= hist_next;
      fill    <= fill_next;
      pattern <= pattern_next;
      len     <= len_next;
      overlap <= overlap_next;
    end
  end

  seqdet_sat_cnt #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (match),
    .count(match_count)
  );

endmodule

// File: tb/tb_seqdet_mealy_prog.sv
// Directed bench for seqdet_mealy_prog: vector table for the main instance,
// hand-written sequences for counter saturation and mid-stream reset.
module tb_seqdet_mealy_prog;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       in_valid = 1'b0, w = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0;
  logic [7:0] cfg_pattern = 8'h00;
  logic [3:0] cfg_len = 4'h0;
  logic       z;
  logic [7:0] match_count;
  logic [2:0] fill;

  logic       s_in_valid = 1'b0, s_w = 1'b0, s_cfg_load = 1'b0, s_cfg_overlap = 1'b0;
  logic [7:0] s_cfg_pattern = 8'h00;
  logic [3:0] s_cfg_len = 4'h0;
  logic       s_z;
  logic [1:0] s_match_count;
  logic [2:0] s_fill;

  always #5 clk = ~clk;

  seqdet_mealy_prog dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .w(w), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .z(z), .match_count(match_count), .fill(fill)
  );

  seqdet_mealy_prog #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .w(s_w), .cfg_load(s_cfg_load),
    .cfg_pattern(s_cfg_pattern), .cfg_len(s_cfg_len), .cfg_overlap(s_cfg_overlap),
    .z(s_z), .match_count(s_match_count), .fill(s_fill)
  );

  typedef struct {
    logic       iv;
    logic       bw;
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov;
    logic       ez;
    logic [7:0] ecnt;
    logic [2:0] efill;
  } vec_t;

  vec_t       vecs[$];
  logic [0:0] exp_q[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic add_bit(input logic bw, input logic ez, input logic [7:0] c, input logic [2:0] f);
    vecs.push_back('{1'b1, bw, 1'b0, 8'h00, 4'h0, 1'b0, ez, c, f});
  endtask

  task automatic add_gap(input logic bw, input logic [7:0] c, input logic [2:0] f);
    vecs.push_back('{1'b0, bw, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, c, f});
  endtask

  task automatic add_load(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                          input logic iv, input logic bw, input logic [7:0] c);
    vecs.push_back('{iv, bw, 1'b1, pat, len, ov, 1'b0, c, 3'd0});
  endtask

  task automatic build_table();
    logic [7:0] p;
    // Defaults (1011, len 4, non-overlap)
    add_bit(1, 0, 0, 1); add_bit(0, 0, 0, 2); add_bit(1, 0, 0, 3); add_bit(1, 1, 1, 0);
    add_bit(0, 0, 1, 1); add_bit(1, 0, 1, 2); add_bit(1, 0, 1, 3);
    // Overlap mode, same stream
    add_load(8'h0B, 4'd4, 1, 0, 0, 1);
    add_bit(1, 0, 1, 1); add_bit(0, 0, 1, 2); add_bit(1, 0, 1, 3); add_bit(1, 1, 2, 4);
    add_bit(0, 0, 2, 5); add_bit(1, 0, 2, 6); add_bit(1, 1, 3, 7);
    // in_valid gaps with w toggling
    add_load(8'h0B, 4'd4, 0, 0, 0, 3);
    add_bit(1, 0, 3, 1); add_bit(0, 0, 3, 2); add_bit(1, 0, 3, 3);
    add_gap(1, 3, 3); add_gap(0, 3, 3); add_gap(1, 3, 3); add_gap(0, 3, 3); add_gap(1, 3, 3);
    add_bit(1, 1, 4, 0);
    // len 8 pattern 11110000
    add_load(8'hF0, 4'd8, 0, 0, 0, 4);
    p = 8'hF0;
    for (int k = 0; k < 7; k++) add_bit(p[7-k], 0, 4, 3'(k + 1));
    add_bit(0, 1, 5, 0);
    for (int k = 0; k < 7; k++) add_bit(p[7-k], 0, 5, 3'(k + 1));
    add_load(8'hF0, 4'd8, 0, 1, 0, 5);
    // len 1
    add_load(8'h01, 4'd1, 0, 0, 0, 5);
    add_bit(1, 1, 6, 0); add_bit(1, 1, 7, 0); add_bit(0, 0, 7, 1); add_bit(1, 1, 8, 0);
    // len 0 disables matching
    add_load(8'h00, 4'd0, 0, 0, 0, 8);
    add_bit(0, 0, 8, 1); add_bit(0, 0, 8, 2); add_bit(0, 0, 8, 3); add_bit(1, 0, 8, 4);
    // cfg_len 15 clamps to 8
    add_load(8'hAA, 4'd15, 0, 0, 0, 8);
    p = 8'hAA;
    for (int k = 0; k < 7; k++) add_bit(p[7-k], 0, 8, 3'(k + 1));
    add_bit(0, 1, 9, 0);
  endtask

  initial begin
    logic [1:0] ec;
    build_table();

    // Reset state
    #2;
    check("rst_z", {7'b0, z}, 8'h00);
    check("rst_count", match_count, 8'h00);
    check("rst_fill", {5'b0, fill}, 8'h00);
    check("rst_s_count", {6'b0, s_match_count}, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_valid    = vecs[i].iv;
      w           = vecs[i].bw;
      cfg_load    = vecs[i].ld;
      cfg_pattern = vecs[i].pat;
      cfg_len     = vecs[i].len;
      cfg_overlap = vecs[i].ov;
      exp_q.push_back(vecs[i].ez);
      #1;
      check($sformatf("vec%0d_z", i), {7'b0, z}, {7'b0, exp_q.pop_front()});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", i), match_count, vecs[i].ecnt);
      check($sformatf("vec%0d_fill", i), {5'b0, fill}, {5'b0, vecs[i].efill});
    end
    @(negedge clk);
    in_valid = 1'b0;
    cfg_load = 1'b0;

    // Saturation: CNT_W = 2, len 1, pattern 1, overlap
    s_cfg_load = 1'b1; s_cfg_pattern = 8'h01; s_cfg_len = 4'd1; s_cfg_overlap = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      s_cfg_load = 1'b0; s_in_valid = 1'b1; s_w = 1'b1;
      #1;
      check($sformatf("sat%0d_z", k), {7'b0, s_z}, 8'h01);
      @(posedge clk);
      #1;
      ec = (k >= 3) ? 2'd3 : 2'(k);
      check($sformatf("sat%0d_count", k), {6'b0, s_match_count}, {6'b0, ec});
      check($sformatf("sat%0d_fill", k), {5'b0, s_fill}, 8'(k));
    end

    // Asynchronous reset in the middle of a cycle, stream still driven
    @(negedge clk);
    #1;
    check("pre_rst_s_z", {7'b0, s_z}, 8'h01);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_s_z", {7'b0, s_z}, 8'h00);
    check("mid_rst_s_count", {6'b0, s_match_count}, 8'h00);
    check("mid_rst_s_fill", {5'b0, s_fill}, 8'h00);
    check("mid_rst_count", match_count, 8'h00);
    check("mid_rst_fill", {5'b0, fill}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_s_z", {7'b0, s_z}, 8'h00);
    @(posedge clk);
    #1;
    check("post_rst_s_fill", {5'b0, s_fill}, 8'h01);
    check("post_rst_s_count", {6'b0, s_match_count}, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seqdet_mealy_prog.md
Name: seqdet_mealy_prog

Overview:
Parametrised, run-time programmable Mealy serial sequence detector; successor to the fixed 4-bit "1011" detector.
- Pattern bits, pattern length (1..MAX_LEN) and overlap/non-overlap mode are loadable at run time.
- Input bits are qualified by a valid strobe.
- Keeps a saturating match counter for status readback.
- Sits on the serial bit stream between the line deserialiser and the control logic that consumes match pulses.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match counter
DEFAULT_PATTERN, 8'b0000_1011, pattern after reset (right-aligned, bit L-1 = first bit received)
DEFAULT_LEN, 4, pattern length after reset
DEFAULT_OVERLAP, 0, overlap mode after reset (0 = non-overlapping)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  w is a valid stream bit this cycle
w  input  1  serial data bit
cfg_load  input  1  one-cycle strobe: latch cfg_* fields
cfg_pattern  input  MAX_LEN  new pattern, right-aligned
cfg_len  input  $clog2(MAX_LEN+1)  new length
cfg_overlap  input  1  new overlap mode
z  output  1  Mealy match output (combinational from w, in_valid, state)
match_count  output  CNT_W  saturating count of asserted z cycles
fill  output  $clog2(MAX_LEN)  current history depth (debug/status)

Behaviour:
- Reset: the asynchronous reset value of every register is as follows.
  - hist = 0, fill = 0, match_count = 0.
  - pattern = DEFAULT_PATTERN, len = DEFAULT_LEN, overlap = DEFAULT_OVERLAP.
  - z = 0 while reset is asserted.
- State:
  - hist[MAX_LEN-2:0] holds the last bits received, newest at bit 0.
  - fill is the number of valid history bits, 0..MAX_LEN-1, saturating at MAX_LEN-1.
- Candidate window = {hist, w}, width MAX_LEN. Match when all of the following hold:
  - in_valid = 1 and cfg_load = 0;
  - len != 0 and fill >= len-1;
  - window[len-1:0] == pattern[len-1:0].
- z = match, with zero latency: asserted in the same cycle as the completing bit. There is no registered output.
- On a valid bit without a match: hist <= {hist[MAX_LEN-3:0], w}; fill <= min(fill+1, MAX_LEN-1).
- On a match:
  - overlap = 1: same update as a non-match (the tail of the pattern can start the next match).
  - overlap = 0: fill <= 0 next cycle. Hist contents are don't-care because fill masks them.
  - match_count <= match_count + 1, saturating at all-ones (no wrap).
- in_valid = 0: hist, fill and match_count hold; z = 0.
- cfg_load = 1:
  - Latch pattern, len and overlap; fill <= 0; match_count is unaffected.
  - The same-cycle w is discarded and z = 0 (cfg_load wins over in_valid).
- cfg_len > MAX_LEN is clamped to MAX_LEN at load. cfg_len = 0 disables matching (z is always 0).
- len = 1: a match occurs on every bit equal to pattern[0]; fill is irrelevant.
- Reset mid-stream: all partial progress is lost immediately; detection restarts after release.

Decomposition:
- Package seqdet_pkg holds:
  - default constants (DEFAULT_PATTERN/LEN/OVERLAP);
  - a localparam helper for the count and length widths;
  - a mask function returning a len-bit right-aligned all-ones mask used for the compare.
- One sub-module, seqdet_sat_cnt: a CNT_W saturating incrementer with async active-low reset, instantiated for match_count.
- Window/compare logic and the fill/hist sequencing stay in the top level.

Test Plan:
- Reset defaults, non-overlap: stream 1,0,1,1,0,1,1 -> z=1 only on bit index 3; match_count = 1; fill = 0 after bit 3, fill = 3 after bit 6.
- Overlap: cfg_load pattern 1011, len 4, overlap = 1; same stream -> z=1 on indices 3 and 6; match_count = 2.
- in_valid gaps: send 1,0,1, then 5 cycles with in_valid = 0 and w toggling, then 1 -> z=0 during the gaps; z=1 on the final valid bit.
- Reprogramming:
  - Load pattern 8'b1111_0000, len 8.
  - Send 11110000 -> z only on the 8th bit.
  - Assert cfg_load on the same cycle as a completing bit -> z=0, fill = 0.
- Corner lengths:
  - len 1, pattern 1: stream 1,1,0,1 -> z = 1,1,0,1.
  - len 0: any stream -> z never asserted.
  - cfg_len = 15 loads as 8.
- Saturation/reset: CNT_W = 2, overlap = 1, len 1, pattern 1; 6 ones -> match_count stops at 3. Async reset low mid-stream -> count, fill and z are 0 immediately.
